dff_exerciser: RTL and testbench



---
 rtl/dff_exerciser.sv | 221 ++++++++++++++++++++++
 tb/tb_dff_exerciser.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_exerciser.sv
// dff_exerciser
// -----------------------------------------------------------------------------
// Self-test engine for a single-bit D flip-flop with synchronous set/reset that
// shares clk with this block. Each pass walks the eight {set,reset,d} vectors
// in order 0..7. For each vector it drives the cell inputs, waits
// SETTLE_CYCLES clocks, then checks q/qbar against
// q_exp = reset ? 0 : (set ? 1 : d). A run ends with a one-cycle done pulse,
// a saturating error count and a pass flag.
//
// Parameters:
//   SETTLE_CYCLES  clocks waited after APPLY before CHECK (1..15)
//   PASSES         full 8-vector sweeps per run (1..255)
//   ERR_W          width of err_count
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              begin a run (sampled in IDLE only)
//   dut_d/set/reset    registered drive to the cell under test
//   dut_q, dut_qbar    cell outputs (X/Z counts as a failure)
//   busy               high from start accept until the done cycle
//   done               one-cycle end-of-run pulse
//   pass               run finished with zero errors; held until next run/reset
//   err_count          saturating mismatch count
//   vector_idx         current vector {set,reset,d}; last checked after done
//   mismatch           one-cycle pulse after each failing check
//
// Optional build macro:
//   DFF_EXER_STOP_ON_ERR_EN  first failing check ends the run immediately,
//                            freezing vector_idx at the failing vector.
// -----------------------------------------------------------------------------
module dff_exerciser #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned PASSES        = 1,
   parameter int unsigned ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             dut_d,
   output logic             dut_set,
   output logic             dut_reset,
   input  logic             dut_q,
   input  logic             dut_qbar,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [2:0]       vector_idx,
   output logic             mismatch
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [3:0] LP_SETTLE    = 4'(SETTLE_CYCLES);
   localparam logic [7:0] LP_LAST_PASS = 8'(PASSES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_wait_cnt;
   logic [7:0]       r_pass_cnt;
   logic             r_dut_d;
   logic             r_dut_set;
   logic             r_dut_reset;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic             r_mismatch;
   logic [ERR_W-1:0] r_err_count;
   logic [2:0]       r_vector_idx;

   logic             w_q_exp;
   logic             w_fail;
   logic             w_last_vec;
   logic             w_last_pass;
   logic             w_accept;
   logic             w_stop;

   // Reference is taken from the pins actually driven, which equal vector_idx
   // throughout CHECK. Reset has priority over set.
   assign w_q_exp     = r_dut_reset ? 1'b0 : (r_dut_set ? 1'b1 : r_dut_d);
   // Case inequality so an unknown q/qbar is reported as a failure.
   assign w_fail      = (dut_q !== w_q_exp) || (dut_qbar !== ~w_q_exp);
   assign w_last_vec  = (r_vector_idx == 3'd7);
   assign w_last_pass = (r_pass_cnt == LP_LAST_PASS);
   // The done pulse is emitted from the DONE state's exit edge, so the FSM is
   // already back in IDLE while done is high; masking here keeps a start
   // during the done cycle ignored.
   assign w_accept    = start && !r_done;

`ifdef DFF_EXER_STOP_ON_ERR_EN
   assign w_stop = w_fail;
`else
   assign w_stop = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_APPLY;
            end
         end
         S_APPLY: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // Counter reaches zero on this edge: WAIT spans SETTLE_CYCLES clocks.
            if (r_wait_cnt <= 4'd1) begin
               w_state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            if (w_stop || (w_last_vec && w_last_pass)) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_APPLY;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait_cnt   <= '0;
         r_pass_cnt   <= '0;
         r_dut_d      <= 1'b0;
         r_dut_set    <= 1'b0;
         r_dut_reset  <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_mismatch   <= 1'b0;
         r_err_count  <= '0;
         r_vector_idx <= '0;
      end else begin
         r_done     <= 1'b0;
         r_mismatch <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_busy       <= 1'b1;
                  r_pass       <= 1'b0;
                  r_err_count  <= '0;
                  r_vector_idx <= '0;
                  r_pass_cnt   <= '0;
               end
            end
            S_APPLY: begin
               r_dut_set   <= r_vector_idx[2];
               r_dut_reset <= r_vector_idx[1];
               r_dut_d     <= r_vector_idx[0];
               r_wait_cnt  <= LP_SETTLE;
            end
            S_WAIT: begin
               r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            S_CHECK: begin
               if (w_fail) begin
                  r_mismatch <= 1'b1;
                  if (r_err_count != '1) begin
                     r_err_count <= r_err_count + ERR_W'(1);
                  end
               end
               if (!w_stop) begin
                  if (!w_last_vec) begin
                     r_vector_idx <= r_vector_idx + 3'd1;
                  end else if (!w_last_pass) begin
                     r_vector_idx <= 3'd0;
                     r_pass_cnt   <= r_pass_cnt + 8'd1;
                  end
               end
            end
            S_DONE: begin
               r_done      <= 1'b1;
               r_busy      <= 1'b0;
               r_pass      <= (r_err_count == '0);
               r_dut_set   <= 1'b0;
               r_dut_d     <= 1'b0;
               r_dut_reset <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign dut_d      = r_dut_d;
   assign dut_set    = r_dut_set;
   assign dut_reset  = r_dut_reset;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign err_count  = r_err_count;
   assign vector_idx = r_vector_idx;
   assign mismatch   = r_mismatch;

endmodule

// File: tb/tb_dff_exerciser.sv
// Testbench for dff_exerciser: three instances with different SETTLE/PASSES/
// ERR_W settings, each driving its own behavioural flip-flop cell with a
// selectable fault, checked every cycle against a run-level reference model.
module tb_dff_exerciser;

`ifdef DFF_EXER_STOP_ON_ERR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [2:0]      d_w, set_w, rst_w, q_w, qbar_w;
   logic [2:0]      busy_w, done_w, pass_w, mm_w;
   logic [2:0][2:0] vec_w;
   logic [7:0]      err0;
   logic [1:0]      err1;
   logic [3:0]      err2;
   int              errv [3];

   always_comb begin
      errv[0] = int'(err0);
      errv[1] = int'(err1);
      errv[2] = int'(err2);
   end

   dff_exerciser #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(8)) u_dut0 (
      .clk(clk), .reset(reset), .start(start),
      .dut_d(d_w[0]), .dut_set(set_w[0]), .dut_reset(rst_w[0]),
      .dut_q(q_w[0]), .dut_qbar(qbar_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .err_count(err0), .vector_idx(vec_w[0]), .mismatch(mm_w[0]));

   dff_exerciser #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(2)) u_dut1 (
      .clk(clk), .reset(reset), .start(start),
      .dut_d(d_w[1]), .dut_set(set_w[1]), .dut_reset(rst_w[1]),
      .dut_q(q_w[1]), .dut_qbar(qbar_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .err_count(err1), .vector_idx(vec_w[1]), .mismatch(mm_w[1]));

   dff_exerciser #(.SETTLE_CYCLES(3), .PASSES(3), .ERR_W(4)) u_dut2 (
      .clk(clk), .reset(reset), .start(start),
      .dut_d(d_w[2]), .dut_set(set_w[2]), .dut_reset(rst_w[2]),
      .dut_q(q_w[2]), .dut_qbar(qbar_w[2]),
      .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
      .err_count(err2), .vector_idx(vec_w[2]), .mismatch(mm_w[2]));

   // ---------------- cells under test (stimulus environment) ----------------
   // fault: 0 good, 1 q stuck 0 / qbar 1, 2 qbar tied to q, 3 q flipped per mask
   int         fault [3] = '{0, 0, 0};
   logic [7:0] mask  [3] = '{8'h00, 8'h00, 8'h00};
   logic [2:0]      cq;
   logic [2:0][2:0] cvec;

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         cq[i]   <= rst_w[i] ? 1'b0 : (set_w[i] ? 1'b1 : d_w[i]);
         cvec[i] <= {set_w[i], rst_w[i], d_w[i]};
      end
   end

   always_comb begin
      q_w    = '0;
      qbar_w = '1;
      for (int i = 0; i < 3; i++) begin
         case (fault[i])
            0:       begin q_w[i] = cq[i];  qbar_w[i] = ~cq[i]; end
            1:       begin q_w[i] = 1'b0;   qbar_w[i] = 1'b1;   end
            2:       begin q_w[i] = cq[i];  qbar_w[i] = cq[i];  end
            default: begin
               q_w[i]    = cq[i] ^ mask[i][cvec[i]];
               qbar_w[i] = ~(cq[i] ^ mask[i][cvec[i]]);
            end
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input int id, input int act, input int exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", nm, id, act, exp_v, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int per_a [3] = '{3, 3, 5};   // SETTLE_CYCLES + 2
   int pas_a [3] = '{1, 2, 3};
   int ew_a  [3] = '{8, 2, 4};

   function automatic bit exp_q(input int v);
      logic [2:0] vv;
      vv = v[2:0];               // {set, reset, d}
      if (vv[1]) return 1'b0;
      if (vv[2]) return 1'b1;
      return vv[0];
   endfunction

   function automatic bit vec_fails(input int mode, input logic [7:0] m, input int v);
      case (mode)
         0:       return 1'b0;
         1:       return exp_q(v);   // q stuck at 0 only wrong when 1 expected
         2:       return 1'b1;
         default: return m[v];
      endcase
   endfunction

   function automatic int sat(input int n, input int ew);
      int mx;
      mx = (1 << ew) - 1;
      return (n > mx) ? mx : n;
   endfunction

   function automatic int model_errs(input int mode, input logic [7:0] m,
                                     input int passes, input int ew, input bit stop);
      int n;
      n = 0;
      for (int k = 0; k < 8 * passes; k++) begin
         if (vec_fails(mode, m, k % 8)) begin
            n++;
            if (stop) break;
         end
      end
      return sat(n, ew);
   endfunction

   bit          model_valid = 1'b0;
   bit          active [3];
   int          t_a    [3];
   int          n_a    [3];    // vectors checked this run
   logic [63:0] fb     [3];    // failing vector flags in check order
   int          h_err  [3];
   int          h_pass [3];
   int          h_vec  [3];

   task automatic check_dut(input int i);
      int per, n, done_t, t, cc, cnt;
      int e_busy, e_done, e_mm, e_pins, e_err, e_pass, e_vec;
      per    = per_a[i];
      n      = n_a[i];
      done_t = n * per + 1;
      t      = t_a[i];
      e_busy = 0; e_done = 0; e_mm = 0; e_pins = 3'b010;
      e_err  = h_err[i]; e_pass = h_pass[i]; e_vec = h_vec[i];
      if (active[i] && t == done_t) begin
         e_done = 1;
      end else if (active[i]) begin
         e_busy = 1;
         e_pass = 0;
         cc = t / per;
         if (cc > n) cc = n;
         cnt = 0;
         for (int k = 0; k < cc; k++) if (fb[i][k]) cnt++;
         e_err = sat(cnt, ew_a[i]);
         e_vec = (cc < n) ? (cc % 8) : ((n - 1) % 8);
         if (t > 0) e_pins = ((t - 1) / per) % 8;
         if (t >= per && t % per == 0 && t / per <= n) e_mm = fb[i][t / per - 1];
      end
      chk("busy",      i, busy_w[i], e_busy);
      chk("done",      i, done_w[i], e_done);
      chk("mismatch",  i, mm_w[i],   e_mm);
      chk("dut_pins",  i, {set_w[i], rst_w[i], d_w[i]}, e_pins);
      chk("err_count", i, errv[i],   e_err);
      chk("pass",      i, pass_w[i], e_pass);
      chk("vector_idx",i, vec_w[i],  e_vec);
   endtask

   initial begin : model_and_compare
      forever begin
         @(posedge clk);
         if (reset) begin
            model_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
               active[i] = 1'b0; h_err[i] = 0; h_pass[i] = 0; h_vec[i] = 0;
            end
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (active[i]) begin
                  t_a[i]++;
                  if (t_a[i] == n_a[i] * per_a[i] + 1) begin
                     int cnt;
                     cnt = 0;
                     for (int k = 0; k < n_a[i]; k++) if (fb[i][k]) cnt++;
                     h_err[i]  = sat(cnt, ew_a[i]);
                     h_pass[i] = (cnt == 0) ? 1 : 0;
                     h_vec[i]  = (n_a[i] - 1) % 8;
                  end
                  if (t_a[i] > n_a[i] * per_a[i] + 1) active[i] = 1'b0;
               end else if (start) begin
                  active[i] = 1'b1;
                  t_a[i]    = 0;
                  n_a[i]    = 8 * pas_a[i];
                  fb[i]     = '0;
                  for (int k = 0; k < 8 * pas_a[i]; k++) begin
                     if (vec_fails(fault[i], mask[i], k % 8)) begin
                        fb[i][k] = 1'b1;
                        if (STOP) begin
                           n_a[i] = k + 1;
                           break;
                        end
                     end
                  end
               end
            end
         end
         @(negedge clk);
         if (model_valid) for (int i = 0; i < 3; i++) check_dut(i);
      end
   end

   // ---------------- stimulus ----------------
   int lat [3];

   task automatic run_all(input int f0, input int f1, input int f2, input int extra);
      bit all;
      fault[0] = f0; fault[1] = f1; fault[2] = f2;
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;       // accept edge is t=0
      for (int i = 0; i < 3; i++) lat[i] = -1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (c == extra) start = 1'b1;
         if (c == extra + 1) start = 1'b0;
         all = 1'b1;
         for (int i = 0; i < 3; i++) begin
            if (lat[i] < 0 && done_w[i]) lat[i] = c;
            if (lat[i] < 0) all = 1'b0;
         end
         if (all) break;
      end
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (lat[i] < 0) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout dut%0d: no done within 600 cycles", i);
         end
      end
   endtask

   task automatic wait_all_idle(input int limit);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < limit && !ok; c++) begin
         @(negedge clk);
         ok = (busy_w == 3'b000) && (done_w == 3'b000) && !active[0] && !active[1] && !active[2];
      end
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL idle_timeout: DUTs still busy after %0d cycles", limit);
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;

      // Model pins
      chk("model_stuck_errs", 0, model_errs(1, 8'h00, 1, 8, 1'b0), 3);
      chk("model_sat_errs",   1, model_errs(1, 8'h00, 2, 2, 1'b0), 3);
      chk("model_qbar_errs",  0, model_errs(2, 8'h00, 1, 8, 1'b0), 8);
      chk("model_qbar_errs",  2, model_errs(2, 8'h00, 3, 4, 1'b0), 15);

      // Golden
      run_all(0, 0, 0, -1);
      chk("golden_latency", 0, lat[0], 25);
      chk("golden_latency", 1, lat[1], 49);
      chk("golden_latency", 2, lat[2], 121);
      chk("golden_err",     0, errv[0], 0);
      chk("golden_pass",    0, pass_w[0], 1);
      chk("golden_vec",     0, vec_w[0], 7);

      // Stuck q (failures at vectors 1, 4, 5)
      run_all(1, 1, 1, -1);
      chk("stuck_latency", 0, lat[0], STOP ? 7 : 25);
      chk("stuck_latency", 1, lat[1], STOP ? 7 : 49);
      chk("stuck_latency", 2, lat[2], STOP ? 11 : 121);
      chk("stuck_err",     0, errv[0], STOP ? 1 : 3);
      chk("stuck_err_sat", 1, errv[1], STOP ? 1 : 3);
      chk("stuck_pass",    0, pass_w[0], 0);
      chk("stuck_vec",     0, vec_w[0], STOP ? 1 : 7);

      // Qbar tied to q
      run_all(2, 2, 2, -1);
      chk("qbar_err", 0, errv[0], STOP ? 1 : 8);
      chk("qbar_err", 2, errv[2], STOP ? 1 : 15);
      chk("qbar_pass", 0, pass_w[0], 0);

      // Start while busy is ignored
      run_all(0, 1, 0, 5);
      chk("busy_start_latency", 0, lat[0], 25);
      chk("busy_start_latency", 1, lat[1], STOP ? 7 : 49);

      // Reset mid-run at cycle 10
      fault[0] = 1; fault[1] = 1; fault[2] = 1;
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (9) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk); #2 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy",   0, busy_w[0], 0);
      chk("rst_dreset", 0, rst_w[0], 1);
      chk("rst_err",    0, errv[0], 0);
      chk("rst_done",   0, done_w[0], 0);
      run_all(0, 0, 0, -1);
      chk("post_rst_latency", 0, lat[0], 25);
      chk("post_rst_pass",    0, pass_w[0], 1);

      // start held high across done cycles
      fault[0] = 3; fault[1] = 1; fault[2] = 2; mask[0] = 8'hA5;
      @(posedge clk); #2 start = 1'b1;
      repeat (260) @(posedge clk);
      #2 start = 1'b0;
      wait_all_idle(400);

      // Randomized runs
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 3; i++) mask[i] = 8'($urandom_range(0, 255));
         run_all(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : -1);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
